// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind the MemRW / dready_n / dbusy handshake,
// with configurable read/write latency. Define DMEM_MISALIGN_EN to add misaligned-access flagging.
module dmem_responder #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemRW,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        dready_n,
  output logic        dbusy
`ifdef DMEM_MISALIGN_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BUSY, DONE} state_t;

  localparam logic [3:0] RD_CNT = (READ_LAT  > 1) ? 4'(READ_LAT - 2)  : 4'd0;
  localparam logic [3:0] WR_CNT = (WRITE_LAT > 1) ? 4'(WRITE_LAT - 2) : 4'd0;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                op, op_nxt;        // 1 = read, 0 = write
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   req_idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic                wr_en;
  logic                rd_load;
  logic [3:0]          be;
  logic [31:0]         wd;
  logic                unused_bits;

  logic [31:0] mem [2**ADDR_W];

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   lane_data = {4{w[7:0]}};
      2'b01:   lane_data = {2{w[15:0]}};
      default: lane_data = w;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  logic mis_q;
  logic req_mis;
  assign req_mis  = is_misaligned(req_size, req_addr[1:0]);
  assign misalign = (state == DONE) && mis_q;
`endif

  // Upper address bits wrap by design
  assign unused_bits = ^req_addr[31:ADDR_W+2];

  assign req_idx = req_addr[ADDR_W+1:2];
  assign rd_idx  = (state == IDLE) ? req_idx : idx_q;
  assign be      = lane_mask(req_size, req_addr[1:0]);
  assign wd      = lane_data(req_size, req_wdata);

  assign dready_n = !((state == DONE) && op);
  assign dbusy    = rst && (((state == IDLE) && (MemRW == 2'b01)) || (state == WR_BUSY));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (MemRW[1]) begin
          op_nxt = 1'b1;
          if (READ_LAT == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = RD_CNT;
          end
        end else if (MemRW[0]) begin
          op_nxt = 1'b0;
          wr_en  = rst;
`ifdef DMEM_MISALIGN_EN
          wr_en  = rst && !req_mis;
`endif
          if (WRITE_LAT == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WR_BUSY;
            cnt_nxt   = WR_CNT;
          end
        end
      end
      RD_WAIT, WR_BUSY: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is captured on the edge that enters DONE
  assign rd_load = (state != DONE) && (state_nxt == DONE) && op_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op    <= 1'b0;
      rdata <= 32'd0;
`ifdef DMEM_MISALIGN_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
      if (rd_load) rdata <= mem[rd_idx];
`ifdef DMEM_MISALIGN_EN
      if ((state == IDLE) && (MemRW != 2'b00)) mis_q <= req_mis;
`endif
    end
  end

  // RAM and latched index carry no reset
  always_ff @(posedge clk) begin
    if ((state == IDLE) && MemRW[1]) idx_q <= req_idx;
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[req_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores with hand-computed expected words.
module tb_dmem_responder;

  localparam int ADDR_W    = 10;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  MemRW;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        dready_n;
  logic        dbusy;
`ifdef DMEM_MISALIGN_EN
  logic        misalign;
`endif

  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  dmem_responder #(
    .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .MemRW(MemRW), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .rdata(rdata), .dready_n(dready_n), .dbusy(dbusy)
`ifdef DMEM_MISALIGN_EN
    , .misalign(misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with read data valid consumes one expected word
  always @(negedge clk) begin
    if (rst === 1'b1 && dready_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dready: got rdata %h with nothing expected", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                          input logic exp_mis);
    int n;
    @(posedge clk); #2;
    MemRW = 2'b01; req_addr = a; req_size = s; req_wdata = d;
    @(negedge clk);
    n = 0;
    while (dbusy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      req_wdata = ~d;   // must not be written again after cycle 0
    end
    chk("dbusy_cycles", 32'(n), 32'(WRITE_LAT));
`ifdef DMEM_MISALIGN_EN
    chk("misalign_done", {31'd0, misalign}, {31'd0, exp_mis});
`else
    if (exp_mis === 1'bx) $display("note: unknown misalign expectation");
`endif
    MemRW = 2'b00;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] mrw, input logic [31:0] exp);
    int n;
    @(posedge clk); #2;
    MemRW = mrw; req_addr = a; req_size = 2'b10; req_wdata = 32'h0000_0099;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("dbusy_on_read", {31'd0, dbusy}, 32'd0);
    n = 0;
    while (dready_n === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("read_latency", 32'(n), 32'(READ_LAT));
    MemRW = 2'b00;
  endtask

  initial begin
    rst = 1'b0; MemRW = 2'b01; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h0;
    #1;
    chk("reset_dready_n", {31'd0, dready_n}, 32'd1);
    chk("reset_dbusy", {31'd0, dbusy}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
`ifdef DMEM_MISALIGN_EN
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
`endif
    MemRW = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_write(32'h40, 2'b10, 32'hDEADBEEF, 1'b0);
    do_read (32'h40, 2'b10, 32'hDEADBEEF);

    do_write(32'h80, 2'b10, 32'h11223344, 1'b0);
    do_write(32'h81, 2'b00, 32'h123456AA, 1'b0);
    do_write(32'h82, 2'b01, 32'hFFFFBBCC, 1'b0);
    do_read (32'h80, 2'b10, 32'hBBCCAA44);

    do_write(32'h84, 2'b10, 32'h00000000, 1'b0);
    do_write(32'h87, 2'b00, 32'h0000005A, 1'b0);
    do_read (32'h84, 2'b10, 32'h5A000000);

    do_write(32'h1040, 2'b10, 32'hCAFEF00D, 1'b0);
    do_read (32'h40,   2'b10, 32'hCAFEF00D);

    do_write(32'h40, 2'b10, 32'h00000005, 1'b0);
    do_read (32'h40, 2'b11, 32'h00000005);
    do_read (32'h40, 2'b10, 32'h00000005);

    // Reset while the read sits in RD_WAIT
    @(posedge clk); #2;
    MemRW = 2'b10; req_addr = 32'h80; req_size = 2'b10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; MemRW = 2'b00;
    #1;
    chk("midreset_dready_n", {31'd0, dready_n}, 32'd1);
    chk("midreset_dbusy", {31'd0, dbusy}, 32'd0);
    chk("midreset_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("midreset_hold_dready_n", {31'd0, dready_n}, 32'd1);
    rst = 1'b1;
    do_read(32'h80, 2'b10, 32'hBBCCAA44);

`ifdef DMEM_MISALIGN_EN
    do_write(32'h40, 2'b10, 32'h12345678, 1'b0);
    do_write(32'h42, 2'b10, 32'hFFFFFFFF, 1'b1);
    do_read (32'h40, 2'b10, 32'h12345678);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage pipeline: it receives load/store requests from the MEM stage and answers them over the same `MemRW` / `dready_n` / `dbusy` handshake the hazard/stall unit consumes. It backs requests with an internal word-organised RAM and adds configurable read and write latency. This lets the pipeline's memory-stall path be exercised with realistic wait cycles. It is the target end of the data-memory interface; the stall unit and MEM stage are the initiator.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words.
- `READ_LAT`, 2, cycles from read acceptance to data valid; legal range 1..15.
- `WRITE_LAT`, 1, number of cycles `dbusy` is high per store; legal range 1..15.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, reset, asynchronous, active-low.
- `MemRW`, in, 2, request: bit1 = read, bit0 = write, 00 = idle.
- `req_addr`, in, 32, byte address.
- `req_size`, in, 2, access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_wdata`, in, 32, store data, right-aligned.
- `rdata`, out, 32, raw aligned word read; valid while `dready_n` = 0.
- `dready_n`, out, 1, low for exactly one cycle when read data is valid.
- `dbusy`, out, 1, high while a store is in progress.

## Operation
- States: IDLE, RD_WAIT, WR_BUSY, DONE. A 4-bit counter `cnt` and a latched op bit are kept alongside the state.
- **IDLE, read** (`MemRW[1]` = 1):
  - Latch the word index `req_addr[ADDR_W+1:2]` and set op to read.
  - If `READ_LAT` = 1, go to DONE; otherwise go to RD_WAIT with `cnt` = `READ_LAT`-2.
- **IDLE, write only** (`MemRW` = 01):
  - The RAM is written on the exiting clock edge using byte lanes.
  - If `WRITE_LAT` = 1, go to DONE; otherwise go to WR_BUSY with `cnt` = `WRITE_LAT`-2.
- **MemRW = 11**: the read wins and the write is dropped.
- **RD_WAIT / WR_BUSY**: go to DONE when `cnt` = 0, otherwise decrement. Inputs are ignored; the initiator holds them.
- **DONE**: lasts one cycle, then go to IDLE. The request on `MemRW` this cycle is ignored, because the pipeline advances during it. A new request is sampled in the following IDLE cycle.
- **Byte lanes** (little-endian):
  - Byte: lane `req_addr[1:0]`, data `req_wdata[7:0]`.
  - Half: lanes {1,0} or {3,2} chosen by `req_addr[1]`; data `req_wdata[15:0]`; `addr[0]` is ignored.
  - Word: all lanes; `addr[1:0]` is ignored.
- **Read data**: `rdata` is the full stored word. Extraction and sign-extension are done by the pipeline. `rdata` is registered when entering DONE and holds its value until the next read completes.
- **Address**: bits above `ADDR_W+1` are ignored, so addresses wrap.
- **RAM**: contents are not reset and are undefined until written.

## Timing
- `dready_n` = !(state == DONE && op == read). Reset value 1.
- `dbusy` = rst && ((state == IDLE && `MemRW` == 01) || state == WR_BUSY). Combinational; reset value 0.
- `rdata` resets to 0.
- **Read accepted in cycle 0**: `dready_n` is 1 in cycles 0..`READ_LAT`-1 and 0 in cycle `READ_LAT`.
- **Write accepted in cycle 0**: `dbusy` is 1 in cycles 0..`WRITE_LAT`-1 and 0 in cycle `WRITE_LAT` (DONE). The RAM is updated at the end of cycle 0.
- **Back-to-back reads**: each read costs `READ_LAT`+1 cycles of responder time. A read of the address just stored returns the new data.
- **Reset mid-operation**: state returns to IDLE immediately and all outputs take their reset values. A store already committed to the RAM stays.

## Configuration
- `DMEM_MISALIGN_EN` defined:
  - Adds output port `misalign` (1 bit, reset 0).
  - A request is misaligned if it is a half with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0.
  - Such a request still follows the normal state/timing path, but a misaligned store does not modify the RAM.
  - `misalign` is high during that request's DONE cycle only.
- Undefined: there is no `misalign` port, and misaligned requests are silently aligned as described under Operation.

## Test plan
- **Word write then read** (`READ_LAT`=2, `WRITE_LAT`=1): store `0xDEADBEEF` @0x40, then load @0x40.
  - Store: `dbusy` = 1 for 1 cycle.
  - Load: `dready_n` = 0 exactly 2 cycles after acceptance, with `rdata` = `0xDEADBEEF`.
- **Byte/half lanes**:
  - Store word `0x11223344` @0x80.
  - Store byte `0xAA` @0x81.
  - Store half `0xBBCC` @0x82.
  - Load @0x80 → `rdata` = `0xBBCCAA44`.
- **Write latency** (`WRITE_LAT`=3, `MemRW` held at 01): `dbusy` is high for 3 cycles, low in DONE, and exactly one RAM write occurs.
- **Simultaneous request** (`MemRW` = 11 @0x40 holding 0x5): read returns 0x5 and the RAM is unchanged.
- **Reset mid-read**: assert `rst` low during RD_WAIT → `dready_n` = 1, `dbusy` = 0 immediately. After release, a new read completes with normal latency.
- **Misalign** (`DMEM_MISALIGN_EN`): word store `0xFFFFFFFF` @0x42 → `misalign` pulses in DONE and the word @0x40 keeps its old value.
